// File: rtl/gshare_ckpt_predictor_if.sv
// Fetch/retire handshake bundle between the front end and the gshare predictor.
interface gshare_ckpt_predictor_if #(
    parameter int CKPT_DEPTH = 16
);
    localparam int TAG_W = $clog2(CKPT_DEPTH);

    logic             enable;
    logic             if_en_branch;
    logic [31:0]      if_pc_in;
    logic             pred_valid;
    logic             pred_taken;
    logic [TAG_W-1:0] pred_tag;
    logic             ckpt_full;
    logic             rt_en_branch;
    logic             rt_branch_taken;
    logic             rt_prediction_correct;

    modport master (
        output enable, if_en_branch, if_pc_in,
        output rt_en_branch, rt_branch_taken, rt_prediction_correct,
        input  pred_valid, pred_taken, pred_tag, ckpt_full
    );

    modport slave (
        input  enable, if_en_branch, if_pc_in,
        input  rt_en_branch, rt_branch_taken, rt_prediction_correct,
        output pred_valid, pred_taken, pred_tag, ckpt_full
    );
endinterface

// File: rtl/gshare_ckpt_predictor.sv
// Gshare direction predictor with saturating PHT counters and a checkpoint queue
// of in-flight branch indices; retire trains the PHT and a mispredict restores history.
module gshare_ckpt_predictor #(
    parameter int BH_SIZE    = 8,
    parameter int CTR_BITS   = 2,
    parameter int CKPT_DEPTH = 16,
    parameter int PC_LSB     = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    gshare_ckpt_predictor_if.slave        bp,
    output logic [BH_SIZE-1:0]            ghr_spec_out,
    output logic [BH_SIZE-1:0]            ghr_commit_out,
    output logic [$clog2(CKPT_DEPTH):0]   ckpt_count_out
);
    localparam int TAG_W = $clog2(CKPT_DEPTH);
    localparam int CNT_W = TAG_W + 1;
    localparam int PHT_N = 1 << BH_SIZE;
    localparam int unsigned CTR_INIT_I = (1 << (CTR_BITS - 1)) - 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_INIT_I[CTR_BITS-1:0];

    function automatic logic [CTR_BITS-1:0] ctr_sat(input logic [CTR_BITS-1:0] c,
                                                    input logic up);
        if (up)
            return (&c) ? c : c + CTR_BITS'(1);
        else
            return (|c) ? c - CTR_BITS'(1) : c;
    endfunction

    logic [CTR_BITS-1:0] pht_q [PHT_N];
    logic [BH_SIZE-1:0]  slot_idx_q [CKPT_DEPTH];

    logic [BH_SIZE-1:0] ghr_spec_q, ghr_spec_d;
    logic [BH_SIZE-1:0] ghr_commit_q, ghr_commit_d;
    logic [TAG_W-1:0]   head_q, head_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [BH_SIZE-1:0] idx;
    logic [BH_SIZE-1:0] ret_idx;
    logic               pred_taken;
    logic               full;
    logic               retire;
    logic               recover;
    logic               push;
    logic               unused_pc;

    assign idx        = bp.if_pc_in[PC_LSB +: BH_SIZE] ^ ghr_spec_q;
    assign pred_taken = pht_q[idx][CTR_BITS-1];
    assign full       = (count_q == CNT_W'(CKPT_DEPTH));
    assign retire     = bp.enable & bp.rt_en_branch & (count_q != '0);
    assign recover    = retire & ~bp.rt_prediction_correct;
    // A recovering cycle drops fetch: the speculative path it belongs to is dead.
    assign push       = bp.enable & bp.if_en_branch & ~full & ~recover;
    assign ret_idx    = slot_idx_q[head_q];
    assign unused_pc  = ^bp.if_pc_in;

    always_comb begin
        ghr_spec_d   = ghr_spec_q;
        ghr_commit_d = ghr_commit_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(retire);
        if (retire) begin
            ghr_commit_d = {ghr_commit_q[BH_SIZE-2:0], bp.rt_branch_taken};
            head_d       = head_q + TAG_W'(1);
        end
        if (push) begin
            ghr_spec_d = {ghr_spec_q[BH_SIZE-2:0], pred_taken};
            tail_d     = tail_q + TAG_W'(1);
        end
        // Restart speculation from committed history including this outcome.
        if (recover) begin
            ghr_spec_d = ghr_commit_d;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghr_spec_q   <= '0;
            ghr_commit_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            for (int i = 0; i < PHT_N; i++)
                pht_q[i] <= CTR_INIT;
        end else begin
            ghr_spec_q   <= ghr_spec_d;
            ghr_commit_q <= ghr_commit_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            if (retire)
                pht_q[ret_idx] <= ctr_sat(pht_q[ret_idx], bp.rt_branch_taken);
        end
    end

    // Checkpoint payload needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push)
            slot_idx_q[tail_q] <= idx;
    end

    assign bp.pred_valid  = push;
    assign bp.pred_taken  = pred_taken;
    assign bp.pred_tag    = tail_q;
    assign bp.ckpt_full   = full;
    assign ghr_spec_out   = ghr_spec_q;
    assign ghr_commit_out = ghr_commit_q;
    assign ckpt_count_out = count_q;
endmodule

// File: tb/tb_gshare_ckpt_predictor.sv
// Directed bench for gshare_ckpt_predictor: predictions go through a scoreboard
// queue checked by a monitor on the falling edge; state is checked after each step.
module tb_gshare_ckpt_predictor;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] ghr_spec_out;
    logic [7:0] ghr_commit_out;
    logic [4:0] ckpt_count_out;

    int total = 0;
    int bad   = 0;
    logic [4:0] sb [$];

    gshare_ckpt_predictor_if #(.CKPT_DEPTH(16)) bp ();

    gshare_ckpt_predictor #(
        .BH_SIZE(8), .CTR_BITS(2), .CKPT_DEPTH(16), .PC_LSB(2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bp             (bp),
        .ghr_spec_out   (ghr_spec_out),
        .ghr_commit_out (ghr_commit_out),
        .ckpt_count_out (ckpt_count_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted prediction must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && bp.pred_valid === 1'b1) begin
            logic [4:0] e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pred_unexpected: got tag=%0d taken=%0b expected no prediction",
                         bp.pred_tag, bp.pred_taken);
            end else begin
                e = sb.pop_front();
                if ({bp.pred_tag, bp.pred_taken} !== e) begin
                    bad++;
                    $display("FAIL pred: got tag=%0d taken=%0b expected tag=%0d taken=%0b",
                             bp.pred_tag, bp.pred_taken, e[4:1], e[0]);
                end
            end
        end
    end

    task automatic idle();
        bp.enable                = 1'b1;
        bp.if_en_branch          = 1'b0;
        bp.if_pc_in              = 32'h0;
        bp.rt_en_branch          = 1'b0;
        bp.rt_branch_taken       = 1'b0;
        bp.rt_prediction_correct = 1'b1;
    endtask

    // Drive one cycle of inputs; ev/etk/etag describe the prediction fetch must yield.
    task automatic step(input logic en, input logic fe, input logic [31:0] pc,
                        input logic re, input logic tk, input logic ok,
                        input logic ev, input logic etk, input int etag);
        logic [3:0] t;
        t = etag[3:0];
        bp.enable                = en;
        bp.if_en_branch          = fe;
        bp.if_pc_in              = pc;
        bp.rt_en_branch          = re;
        bp.rt_branch_taken       = tk;
        bp.rt_prediction_correct = ok;
        if (ev)
            sb.push_back({t, etk});
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic chk_state(input string name, input int cnt,
                             input logic [7:0] spec, input logic [7:0] com);
        chk({name, "_count"}, 32'(ckpt_count_out), 32'(cnt));
        chk({name, "_spec"}, 32'(ghr_spec_out), 32'(spec));
        chk({name, "_commit"}, 32'(ghr_commit_out), 32'(com));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #12;
        chk("rst_pred_valid", 32'(bp.pred_valid), 0);
        chk("rst_pred_taken", 32'(bp.pred_taken), 0);
        chk("rst_pred_tag", 32'(bp.pred_tag), 0);
        chk("rst_full", 32'(bp.ckpt_full), 0);
        chk_state("rst", 0, 8'h00, 8'h00);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Training on PHT[0x14]: 01 -> 10 -> 11 -> 11 (saturate) -> 10 -> 11
        step(1, 1, 32'h50, 0, 0, 1, 1, 0, 0);
        chk_state("a1", 1, 8'h00, 8'h00);
        step(1, 0, 32'h0, 1, 1, 1, 0, 0, 0);
        chk_state("a2", 0, 8'h00, 8'h01);
        step(1, 1, 32'h50, 0, 0, 1, 1, 1, 1);
        chk_state("a3", 1, 8'h01, 8'h01);
        step(1, 0, 32'h0, 1, 1, 1, 0, 0, 0);
        step(1, 1, 32'h54, 0, 0, 1, 1, 1, 2);
        step(1, 0, 32'h0, 1, 1, 1, 0, 0, 0);
        chk_state("a6", 0, 8'h03, 8'h07);
        step(1, 1, 32'h5C, 0, 0, 1, 1, 1, 3);
        step(1, 0, 32'h0, 1, 0, 1, 0, 0, 0);
        chk_state("a8", 0, 8'h07, 8'h0E);
        step(1, 1, 32'h4C, 0, 0, 1, 1, 1, 4);
        step(1, 0, 32'h0, 1, 1, 1, 0, 0, 0);
        chk_state("a10", 0, 8'h0F, 8'h1D);

        // PHT[0x00]: 01 -> 00 -> 00 (clamp), predictions stay not-taken
        step(1, 1, 32'h3C, 0, 0, 1, 1, 0, 5);
        step(1, 0, 32'h0, 1, 0, 1, 0, 0, 0);
        step(1, 1, 32'h78, 0, 0, 1, 1, 0, 6);
        step(1, 0, 32'h0, 1, 0, 1, 0, 0, 0);
        step(1, 1, 32'hF0, 0, 0, 1, 1, 0, 7);
        step(1, 0, 32'h0, 1, 0, 1, 0, 0, 0);
        chk_state("b6", 0, 8'h78, 8'hE8);

        // Retire (even mispredicted) with an empty queue is ignored
        step(1, 0, 32'h0, 1, 1, 0, 0, 0, 0);
        chk_state("empty_rt", 0, 8'h78, 8'hE8);

        // enable=0 freezes everything
        step(1, 1, 32'h0, 0, 0, 1, 1, 0, 8);
        step(0, 1, 32'h0, 1, 1, 0, 0, 0, 0);
        chk_state("disabled", 1, 8'hF0, 8'hE8);
        step(1, 0, 32'h0, 1, 1, 1, 0, 0, 0);
        chk_state("e2", 0, 8'hF0, 8'hD1);

        // Fill the queue; tags wrap from 15 to 0
        for (int n = 0; n < 16; n++)
            step(1, 1, 32'h0, 0, 0, 1, 1, 0, (9 + n) % 16);
        chk("full_flag", 32'(bp.ckpt_full), 1);
        chk_state("full", 16, 8'h00, 8'hD1);
        step(1, 1, 32'h0, 0, 0, 1, 0, 0, 0);
        chk("full_hold", 32'(ckpt_count_out), 16);
        step(1, 1, 32'h0, 1, 1, 1, 0, 0, 0);
        chk("full_free_flag", 32'(bp.ckpt_full), 0);
        chk_state("full_free", 15, 8'h00, 8'hA3);
        step(1, 1, 32'h0, 0, 0, 1, 1, 0, 9);
        chk("refill", 32'(ckpt_count_out), 16);
        step(1, 0, 32'h0, 1, 0, 1, 0, 0, 0);
        chk_state("f20", 15, 8'h00, 8'h46);
        step(1, 1, 32'h0, 1, 1, 1, 1, 0, 10);
        chk_state("pushpop", 15, 8'h00, 8'h8D);

        // Mispredict flush with a concurrent fetch that must be dropped
        step(1, 1, 32'h0, 1, 1, 0, 0, 0, 0);
        chk_state("flush", 0, 8'h1B, 8'h1B);
        for (int n = 0; n < 5; n++)
            step(1, 1, 32'h0, 0, 0, 1, 1, 0, n);
        chk_state("pre_rst", 5, 8'h60, 8'h1B);

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        chk_state("async_rst", 0, 8'h00, 8'h00);
        chk("async_rst_tag", 32'(bp.pred_tag), 0);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Recovery after three not-taken predictions
        step(1, 1, 32'h50, 0, 0, 1, 1, 0, 0);
        step(1, 1, 32'h54, 0, 0, 1, 1, 0, 1);
        step(1, 1, 32'h58, 0, 0, 1, 1, 0, 2);
        chk("r3_count", 32'(ckpt_count_out), 3);
        step(1, 1, 32'h50, 1, 1, 0, 0, 0, 0);
        chk_state("recover", 0, 8'h01, 8'h01);
        step(1, 1, 32'h54, 0, 0, 1, 1, 1, 0);
        chk_state("r5", 1, 8'h03, 8'h01);
        // Same-index retire 10->01 while fetching: fetch sees the old counter
        step(1, 1, 32'h5C, 1, 0, 1, 1, 1, 1);
        chk_state("rbw", 1, 8'h07, 8'h02);
        step(1, 1, 32'h4C, 0, 0, 1, 1, 0, 2);
        chk_state("r7", 2, 8'h0E, 8'h02);

        // Twenty alloc/retire pairs: tags keep wrapping, occupancy constant
        for (int n = 0; n < 20; n++)
            step(1, 1, 32'h0, 1, 0, 1, 1, 0, (3 + n) % 16);
        chk_state("wrap", 2, 8'h00, 8'h00);

        @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
